uid_directory: RTL and testbench
================================

// Module: uid_directory
// PURPOSE
//   Responder side of the internal-ID -> user-ID lookup used by Scoring. Holds a table of
//   enrolled 4-digit BCD user IDs indexed by 3-bit internal ID (1..NUM_SLOTS; 0 = guest/none).
//   Returns the 16-bit UID for an internal ID at fixed latency, well inside Scoring's 5-cycle wait.
//   Also enrolls new users from serial keypad digits and resolves UID -> internal ID for login.
// PARAMETERS
//   NUM_SLOTS   7   enrolled-user capacity; internal IDs 1..NUM_SLOTS
//   ID_W        3   internal ID width on enroll/search ports
//   DIGITS      4   BCD digits per UID (UID width = 4*DIGITS = 16)
// PORTS
//   clk          in   1   system clock, all state on posedge
//   rst          in   1   synchronous reset, active-low (rst==0 resets on posedge clk)
//   rdAddr       in   5   internal ID to look up (Scoring intIDout)
//   rdData       out  16  UID for rdAddr; [15:12] first-entered digit .. [3:0] last (Scoring topID)
//   enrollStart  in   1   1-cycle pulse: begin collecting a new UID
//   digitIn      in   4   keypad BCD digit
//   digitValid   in   1   digitIn valid this cycle
//   enrollDone   out  1   1-cycle pulse: enrollment finished
//   enrollID     out  3   assigned (or existing, on dup) internal ID; 0 on failure
//   enrollFull   out  1   with enrollDone: table full, nothing written
//   enrollDup    out  1   with enrollDone: UID already enrolled, nothing written
//   searchStart  in   1   1-cycle pulse: look up searchUID
//   searchUID    in   16  UID to resolve, same digit order as rdData
//   searchDone   out  1   1-cycle pulse: search finished
//   searchHit    out  1   with searchDone: UID found
//   searchID     out  3   internal ID of match; 0 on miss
//   busy         out  1   1 in any state other than IDLE
// BEHAVIOUR
//   Reset: all slot valid bits 0, entries 16'h0000; every output 0; FSM -> IDLE; reset mid-op aborts it.
//   Read port (independent of FSM, never stalls): stage 1 registers rdAddr, stage 2 registers data;
//     rdData valid 2 cycles after rdAddr is presented. rdAddr==0, rdAddr>NUM_SLOTS or slot not valid
//     -> 16'h0000. Slot written on the same edge stage 2 samples -> old value returned.
//   FSM states: IDLE, COLLECT, SCAN, COMMIT, DONE.
//   IDLE: enrollStart -> COLLECT (digit count=0, shift reg cleared); else searchStart -> SCAN
//     (mode=search, latch searchUID). Both same cycle: enroll wins, search dropped. Starts while busy ignored.
//   COLLECT: on digitValid with digitIn<=9, shift digit in at [3:0], count+1; digitIn>9 ignored.
//     4th accepted digit -> SCAN (mode=enroll). Digit entry has no timeout.
//   SCAN: slot index k=1..NUM_SLOTS, one slot per cycle; match = valid[k] && entry[k]==key.
//     Match -> DONE with hit, ID=k. k==NUM_SLOTS without match -> search: DONE miss; enroll: COMMIT.
//   COMMIT: lowest-index slot with valid==0 gets key, valid set, enrollID=slot; none free -> enrollFull=1,
//     enrollID=0. UID 16'h0000 is legal. Then DONE.
//   DONE: single-cycle pulse of enrollDone or searchDone with flags; -> IDLE. Flags/IDs hold until next DONE.
//   Latency: search match at slot k -> searchDone k+1 cycles after searchStart; miss -> NUM_SLOTS+1.
//     Enroll: 4th digit edge -> enrollDone within NUM_SLOTS+2 cycles.
//   Entries are never deleted except by reset.
// STRUCTURE
//   Shared package: FSM state encodings, NUM_SLOTS, UID_W=16, BCD_W=4, GUEST_ID=0, RD_LATENCY=2.
//   Sub-module uid_bcd_collector: 4-digit BCD shift register + digit counter, rejects digits >9,
//     asserts complete on 4th digit. Table, read pipe, scan and FSM live in uid_directory.
// TESTING
//   Reset, rdAddr=1..7 -> rdData=16'h0000 two cycles later; all outputs 0.
//   Enroll digits 1,2,3,4 -> enrollDone, enrollID=1; rdAddr=1 -> rdData=16'h1234 after 2 cycles.
//   Enroll 1,A,2,3,4 -> digit A ignored, stored 16'h1234 -> enrollDup=1, enrollID=1, no write.
//   Fill slots 1..7 with 16'h0001..16'h0007, enroll 9999 -> enrollFull=1, enrollID=0.
//   searchUID=16'h0005 -> searchDone 6 cycles after start, hit=1, ID=5; 16'h8888 -> 8 cycles, miss, ID=0.
//   enrollStart+searchStart same cycle -> enroll path only; rst=0 during COLLECT -> IDLE, table cleared.

Source files
------------

// File: rtl/uid_directory_pkg.sv
// Shared types and constants for the internal-ID <-> user-ID directory.
package uid_directory_pkg;

  localparam int NUM_SLOTS  = 7;
  localparam int ID_W       = 3;
  localparam int DIGITS     = 4;
  localparam int BCD_W      = 4;
  localparam int UID_W      = DIGITS * BCD_W;
  localparam int ADDR_W     = 5;
  localparam int RD_LATENCY = 2;
  localparam int CNT_W      = $clog2(DIGITS);

  localparam logic [ID_W-1:0] GUEST_ID = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SCAN,
    S_COMMIT,
    S_DONE
  } state_t;

  typedef enum logic {
    M_SEARCH,
    M_ENROLL
  } mode_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/uid_bcd_collector.sv
// Four-digit BCD keypad shift register; non-decimal keys are dropped.
module uid_bcd_collector
  import uid_directory_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [BCD_W-1:0] digit,
  input  logic             valid,
  output logic [UID_W-1:0] uid_next,
  output logic             complete
);

  logic [UID_W-1:0] uid;
  logic [CNT_W-1:0] count;
  logic             take;

  assign take     = en && valid && is_bcd(digit);
  assign uid_next = {uid[UID_W-BCD_W-1:0], digit};
  assign complete = take && (count == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      uid   <= '0;
      count <= '0;
    end else if (clear) begin
      uid   <= '0;
      count <= '0;
    end else if (take) begin
      uid   <= uid_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uid_directory.sv
// UID directory: fixed-latency ID->UID read port plus enroll/search FSM
// scanning the table one slot per cycle.
module uid_directory
  import uid_directory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [UID_W-1:0]  rdData,
  input  logic              enrollStart,
  input  logic [BCD_W-1:0]  digitIn,
  input  logic              digitValid,
  output logic              enrollDone,
  output logic [ID_W-1:0]   enrollID,
  output logic              enrollFull,
  output logic              enrollDup,
  input  logic              searchStart,
  input  logic [UID_W-1:0]  searchUID,
  output logic              searchDone,
  output logic              searchHit,
  output logic [ID_W-1:0]   searchID,
  output logic              busy
);

  state_t           state;
  mode_t            mode;
  logic [UID_W-1:0] key;
  logic [ID_W-1:0]  idx;
  logic [UID_W-1:0] entry [NUM_SLOTS+1];
  logic [NUM_SLOTS:0] valid;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_hit;
  logic [ID_W-1:0]   rd_slot;

  logic [UID_W-1:0] uid_next;
  logic             complete;
  logic             match;
  logic             last;
  logic [ID_W-1:0]  free_id;

  uid_bcd_collector u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_IDLE && enrollStart),
    .en       (state == S_COLLECT),
    .digit    (digitIn),
    .valid    (digitValid),
    .uid_next (uid_next),
    .complete (complete)
  );

  assign busy = (state != S_IDLE);

  // Read pipe: address register, then data register.
  assign rd_slot = rd_addr_q[ID_W-1:0];
  assign rd_hit  = (rd_addr_q != '0) &&
                   (rd_addr_q <= ADDR_W'(NUM_SLOTS)) &&
                   valid[rd_slot];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rdData    <= '0;
    end else begin
      rd_addr_q <= rdAddr;
      rdData    <= rd_hit ? entry[rd_slot] : '0;
    end
  end

  assign match = valid[idx] && (entry[idx] == key);
  assign last  = (idx == ID_W'(NUM_SLOTS));

  always_comb begin
    free_id = GUEST_ID;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      if (!valid[k]) free_id = ID_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      mode       <= M_SEARCH;
      key        <= '0;
      idx        <= '0;
      valid      <= '0;
      enrollDone <= 1'b0;
      enrollID   <= GUEST_ID;
      enrollFull <= 1'b0;
      enrollDup  <= 1'b0;
      searchDone <= 1'b0;
      searchHit  <= 1'b0;
      searchID   <= GUEST_ID;
      for (int k = 0; k <= NUM_SLOTS; k++) entry[k] <= '0;
    end else begin
      enrollDone <= 1'b0;
      searchDone <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enrollStart) begin
            state <= S_COLLECT;
          end else if (searchStart) begin
            mode  <= M_SEARCH;
            key   <= searchUID;
            idx   <= ID_W'(1);
            state <= S_SCAN;
          end
        end
        S_COLLECT: begin
          if (complete) begin
            mode  <= M_ENROLL;
            key   <= uid_next;
            idx   <= ID_W'(1);
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (match) begin
            state <= S_DONE;
            if (mode == M_SEARCH) begin
              searchDone <= 1'b1;
              searchHit  <= 1'b1;
              searchID   <= idx;
            end else begin
              enrollDone <= 1'b1;
              enrollDup  <= 1'b1;
              enrollFull <= 1'b0;
              enrollID   <= idx;
            end
          end else if (last) begin
            if (mode == M_SEARCH) begin
              state      <= S_DONE;
              searchDone <= 1'b1;
              searchHit  <= 1'b0;
              searchID   <= GUEST_ID;
            end else begin
              state <= S_COMMIT;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_COMMIT: begin
          state      <= S_DONE;
          enrollDone <= 1'b1;
          enrollDup  <= 1'b0;
          if (free_id != GUEST_ID) begin
            valid[free_id] <= 1'b1;
            entry[free_id] <= key;
            enrollFull     <= 1'b0;
            enrollID       <= free_id;
          end else begin
            enrollFull <= 1'b1;
            enrollID   <= GUEST_ID;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uid_directory.sv
// Randomized bench for uid_directory against a slot-array reference model.
module tb_uid_directory;

  localparam int NUM = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rdAddr;
  logic [15:0] rdData;
  logic        enrollStart;
  logic [3:0]  digitIn;
  logic        digitValid;
  logic        enrollDone;
  logic [2:0]  enrollID;
  logic        enrollFull;
  logic        enrollDup;
  logic        searchStart;
  logic [15:0] searchUID;
  logic        searchDone;
  logic        searchHit;
  logic [2:0]  searchID;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int sd_pulses = 0;

  logic [15:0] m_uid [NUM+1];
  bit          m_valid [NUM+1];

  uid_directory dut (
    .clk         (clk),
    .rst         (rst),
    .rdAddr      (rdAddr),
    .rdData      (rdData),
    .enrollStart (enrollStart),
    .digitIn     (digitIn),
    .digitValid  (digitValid),
    .enrollDone  (enrollDone),
    .enrollID    (enrollID),
    .enrollFull  (enrollFull),
    .enrollDup   (enrollDup),
    .searchStart (searchStart),
    .searchUID   (searchUID),
    .searchDone  (searchDone),
    .searchHit   (searchHit),
    .searchID    (searchID),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (searchDone) sd_pulses++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_find(input logic [15:0] u);
    for (int k = 1; k <= NUM; k++)
      if (m_valid[k] && m_uid[k] == u) return k;
    return 0;
  endfunction

  function automatic int m_free();
    for (int k = 1; k <= NUM; k++)
      if (!m_valid[k]) return k;
    return 0;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] u;
    for (int i = 0; i < 4; i++) u[4*i +: 4] = 4'($urandom_range(0, 9));
    return u;
  endfunction

  task automatic m_clear();
    for (int k = 0; k <= NUM; k++) begin
      m_valid[k] = 1'b0;
      m_uid[k]   = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enrollStart = 1'b0;
    searchStart = 1'b0;
    digitValid = 1'b0;
    digitIn = 4'h0;
    tick();
    tick();
    rst = 1'b1;
    m_clear();
  endtask

  task automatic read_check(input int a);
    logic [15:0] exp;
    rdAddr = 5'(a);
    tick();
    tick();
    exp = (a >= 1 && a <= NUM && m_valid[a]) ? m_uid[a] : 16'h0000;
    check($sformatf("rd%0d", a), rdData, exp);
  endtask

  // junk_pos: insert a non-decimal key before digit index junk_pos (-1 none)
  task automatic enroll(input logic [15:0] u, input int junk_pos,
                        input bit both);
    int cnt, dup, fr, pulses0;
    dup = m_find(u);
    fr  = m_free();
    pulses0 = sd_pulses;
    enrollStart = 1'b1;
    if (both) begin
      searchStart = 1'b1;
      searchUID = u;
    end
    tick();
    enrollStart = 1'b0;
    searchStart = 1'b0;
    check("busy_enr", busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == junk_pos) begin
        digitIn = 4'($urandom_range(10, 15));
        digitValid = 1'b1;
        tick();
        digitValid = 1'b0;
        tick();
      end
      digitIn = u[15-4*i -: 4];
      digitValid = 1'b1;
      tick();
    end
    digitValid = 1'b0;
    cnt = 0;
    while (!enrollDone && cnt < 20) begin
      tick();
      cnt++;
    end
    check("enr_lat_ok", (cnt >= 1 && cnt <= NUM + 2), 1);
    if (dup != 0) begin
      check("enr_dup", enrollDup, 1);
      check("enr_full", enrollFull, 0);
      check("enr_id", enrollID, dup);
    end else if (fr != 0) begin
      check("enr_dup", enrollDup, 0);
      check("enr_full", enrollFull, 0);
      check("enr_id", enrollID, fr);
      m_valid[fr] = 1'b1;
      m_uid[fr] = u;
    end else begin
      check("enr_dup", enrollDup, 0);
      check("enr_full", enrollFull, 1);
      check("enr_id", enrollID, 0);
    end
    tick();
    check("enr_pulse", enrollDone, 0);
    check("idle_enr", busy, 0);
    if (both) check("both_nosearch", sd_pulses, pulses0);
  endtask

  task automatic search(input logic [15:0] u);
    int cnt, k;
    k = m_find(u);
    searchUID = u;
    searchStart = 1'b1;
    tick();
    searchStart = 1'b0;
    searchUID = rand_bcd();
    cnt = 1;
    while (!searchDone && cnt < 20) begin
      tick();
      cnt++;
    end
    check("srch_lat", cnt, (k != 0) ? k + 1 : NUM + 1);
    check("srch_hit", searchHit, (k != 0));
    check("srch_id", searchID, k);
    tick();
    check("srch_pulse", searchDone, 0);
  endtask

  initial begin
    rdAddr = '0;
    searchUID = '0;
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_edone", enrollDone, 0);
    check("rst_sdone", searchDone, 0);
    check("rst_eid", enrollID, 0);
    check("rst_flags", {enrollFull, enrollDup, searchHit}, 0);
    check("rst_sid", searchID, 0);
    for (int a = 1; a <= NUM; a++) read_check(a);

    enroll(16'h1234, -1, 1'b0);
    check("first_id", enrollID, 1);
    read_check(1);
    check("rd1234", rdData, 16'h1234);

    enroll(16'h1234, 1, 1'b0);
    check("dup_flag", enrollDup, 1);
    read_check(2);

    do_reset();
    for (int k = 1; k <= NUM; k++) enroll(16'(k), -1, 1'b0);
    enroll(16'h9999, -1, 1'b0);
    check("full_flag", enrollFull, 1);
    for (int a = 0; a <= 9; a++) read_check(a);
    read_check(31);

    search(16'h0005);
    search(16'h8888);
    search(16'h0001);
    search(16'h0007);

    enroll(16'h0003, 2, 1'b1);

    do_reset();
    enroll(16'h0420, -1, 1'b0);
    enrollStart = 1'b1;
    tick();
    enrollStart = 1'b0;
    digitIn = 4'h5;
    digitValid = 1'b1;
    tick();
    tick();
    digitValid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_clear();
    check("abort_busy", busy, 0);
    for (int a = 1; a <= 3; a++) read_check(a);
    enroll(16'h4321, -1, 1'b0);
    enroll(16'h0000, -1, 1'b0);
    search(16'h0000);
    read_check(2);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [15:0] u;
      r = $urandom_range(0, 19);
      if ($urandom_range(0, 1) == 1) u = m_uid[$urandom_range(1, NUM)];
      else u = rand_bcd();
      if (r < 10) begin
        int jp;
        jp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
        enroll(u, jp, 1'b0);
      end else if (r < 19) begin
        search(u);
      end else begin
        do_reset();
      end
      read_check($urandom_range(0, 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
